// File: rtl/step_report_tx.sv
// rtl/step_report_tx.sv - "$PSTEP,sssss,mmmmm[*HH]\r\n" sentence builder and 8N1 UART transmitter
// Optional checksum field "*HH" is built when STEP_TX_CHECKSUM_EN is defined.
module step_report_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [15:0] step_count,
    input  logic [15:0] spm,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] STOP_END = CW'(CPB - 2);
`ifdef STEP_TX_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd22;
`else
    localparam logic [4:0] LAST_IDX = 5'd19;
`endif

    typedef enum logic [2:0] {
        IDLE, CONVERT, LOAD, START, DATA, STOP, FINISH
    } state_t;

    state_t         state;
    logic [15:0]    step_bin;
    logic [15:0]    spm_bin;
    logic [19:0]    step_bcd;
    logic [19:0]    spm_bcd;
    logic [3:0]     conv_cnt;
    logic [4:0]     idx;
    logic [CW-1:0]  clk_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [7:0]     cur_byte;
`ifdef STEP_TX_CHECKSUM_EN
    logic [7:0]     chk;
`endif

    // One double-dabble iteration: add-3 on digits >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dd_step(input logic [19:0] bcd, input logic bin_msb);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj[18:0], bin_msb};
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] d);
        return {4'h3, d};
    endfunction

`ifdef STEP_TX_CHECKSUM_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            5'd0:  cur_byte = 8'h24;
            5'd1:  cur_byte = 8'h50;
            5'd2:  cur_byte = 8'h53;
            5'd3:  cur_byte = 8'h54;
            5'd4:  cur_byte = 8'h45;
            5'd5:  cur_byte = 8'h50;
            5'd6:  cur_byte = 8'h2C;
            5'd7:  cur_byte = digit(step_bcd[19:16]);
            5'd8:  cur_byte = digit(step_bcd[15:12]);
            5'd9:  cur_byte = digit(step_bcd[11:8]);
            5'd10: cur_byte = digit(step_bcd[7:4]);
            5'd11: cur_byte = digit(step_bcd[3:0]);
            5'd12: cur_byte = 8'h2C;
            5'd13: cur_byte = digit(spm_bcd[19:16]);
            5'd14: cur_byte = digit(spm_bcd[15:12]);
            5'd15: cur_byte = digit(spm_bcd[11:8]);
            5'd16: cur_byte = digit(spm_bcd[7:4]);
            5'd17: cur_byte = digit(spm_bcd[3:0]);
`ifdef STEP_TX_CHECKSUM_EN
            5'd18: cur_byte = 8'h2A;
            5'd19: cur_byte = hex_char(chk[7:4]);
            5'd20: cur_byte = hex_char(chk[3:0]);
            5'd21: cur_byte = 8'h0D;
            5'd22: cur_byte = 8'h0A;
`else
            5'd18: cur_byte = 8'h0D;
            5'd19: cur_byte = 8'h0A;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // STOP hands over to LOAD (or FINISH) one cycle early; that cycle is the last stop-bit cycle,
    // so consecutive bytes have no idle gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_bin <= '0;
            spm_bin  <= '0;
            step_bcd <= '0;
            spm_bcd  <= '0;
            conv_cnt <= '0;
            idx      <= '0;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef STEP_TX_CHECKSUM_EN
            chk      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        step_bin <= step_count;
                        spm_bin  <= spm;
                        step_bcd <= '0;
                        spm_bcd  <= '0;
                        conv_cnt <= '0;
                        idx      <= '0;
`ifdef STEP_TX_CHECKSUM_EN
                        chk      <= '0;
`endif
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    step_bcd <= dd_step(step_bcd, step_bin[15]);
                    spm_bcd  <= dd_step(spm_bcd, spm_bin[15]);
                    step_bin <= {step_bin[14:0], 1'b0};
                    spm_bin  <= {spm_bin[14:0], 1'b0};
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd15) state <= LOAD;
                end
                LOAD: begin
                    shreg   <= cur_byte;
                    tx      <= 1'b0;
                    clk_cnt <= '0;
`ifdef STEP_TX_CHECKSUM_EN
                    if (idx >= 5'd1 && idx <= 5'd17) chk <= chk ^ cur_byte;
`endif
                    state   <= START;
                end
                START: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == STOP_END) begin
                        clk_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= LOAD;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_report_tx.sv
// tb/tb_step_report_tx.sv - self-checking bench for step_report_tx (CLK_HZ=1000, BAUD=100)
module tb_step_report_tx;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send = 1'b0;
    logic [15:0] step_count = '0;
    logic [15:0] spm = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic tx_s   [0:2499];
    logic busy_s [0:2499];
    logic done_s [0:2499];

    typedef struct {
        logic [15:0] st;
        logic [15:0] sp;
        string       head;
    } vec_t;

    step_report_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .step_count (step_count),
        .spm        (spm),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference sentence without the trailing CR LF, built from the textual format.
    function automatic string model_head(input int st, input int sp);
        string body;
        body = $sformatf("PSTEP,%05d,%05d", st, sp);
`ifdef STEP_TX_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < body.len(); i++) x ^= body[i];
            return {"$", body, "*", $sformatf("%02X", x)};
        end
`else
        return {"$", body};
`endif
    endfunction

    function automatic string show(input logic [7:0] b [0:31], input int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) begin
            if (b[i] < 8'h20 || b[i] > 8'h7E) s = {s, "."};
            else s = $sformatf("%s%c", s, b[i]);
        end
        return s;
    endfunction

    task automatic check(input bit ok, input string name, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic check_idle(input int n, input string name);
        int bad;
        bad = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if ((tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) && bad < 0) bad = k;
        end
        check(bad < 0, name, $sformatf("activity at idle cycle %0d", bad), "tx=1 busy=0 done=0");
    endtask

    // Records one frame cycle by cycle from the accept edge and compares with the ideal timeline.
    task automatic run_frame(input logic [15:0] st, input logic [15:0] sp, input string head,
                             input string name, input bit predriven, input bit chain,
                             input logic [15:0] nst, input logic [15:0] nsp, input bit noisy);
        logic [7:0] eb [0:31];
        logic [7:0] db [0:31];
        int  n, len, kmax, bad_k, r, bi, j;
        logic etx, ebusy, edone;
        bit  text_ok;
        n = head.len();
        for (int i = 0; i < n; i++) eb[i] = head[i];
        eb[n] = 8'h0D;
        eb[n+1] = 8'h0A;
        n = n + 2;
        len = 17 + 10 * CPB * n;
        kmax = chain ? len : len + 1;
        if (!predriven) begin
            @(negedge clk);
            step_count = st;
            spm = sp;
            send = 1'b1;
        end
        for (int k = 0; k <= kmax; k++) begin
            @(posedge clk); #1;
            tx_s[k] = tx;
            busy_s[k] = busy;
            done_s[k] = done;
            send = 1'b0;
            if (k == 2) begin
                step_count = 16'($urandom);
                spm = 16'($urandom);
            end
            if (noisy && (k == 5 || k == 400 || k == len - 5)) begin
                send = 1'b1;
                step_count = 16'hFFFF;
            end
            if (chain && k == len) begin
                step_count = nst;
                spm = nsp;
                send = 1'b1;
            end
        end
        bad_k = -1;
        etx = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            ebusy = (k < len);
            edone = (k == len);
            if (k < 17 || k >= len) etx = 1'b1;
            else begin
                r  = k - 17;
                bi = r / (10 * CPB);
                j  = (r % (10 * CPB)) / CPB;
                etx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[bi][j-1];
            end
            if (bad_k < 0 && (tx_s[k] !== etx || busy_s[k] !== ebusy || done_s[k] !== edone)) begin
                bad_k = k;
                check(1'b0, {name, " wave"},
                      $sformatf("cycle %0d tx/busy/done=%b%b%b", k, tx_s[k], busy_s[k], done_s[k]),
                      $sformatf("%b%b%b", etx, ebusy, edone));
            end
        end
        if (bad_k < 0) check(1'b1, {name, " wave"}, "", "");
        text_ok = 1'b1;
        for (int b = 0; b < n; b++) begin
            for (int q = 0; q < 8; q++) db[b][q] = tx_s[17 + 10*CPB*b + CPB*(q+1) + CPB/2];
            if (db[b] !== eb[b]) text_ok = 1'b0;
        end
        check(text_ok, {name, " text"}, show(db, n), show(eb, n));
    endtask

    vec_t vt [3];

    initial begin
`ifdef STEP_TX_CHECKSUM_EN
        vt[0] = '{16'd123,   16'd45,    "$PSTEP,00123,00045*43"};
        vt[1] = '{16'd0,     16'd0,     "$PSTEP,00000,00000*42"};
        vt[2] = '{16'd65535, 16'd65535, "$PSTEP,65535,65535*42"};
`else
        vt[0] = '{16'd123,   16'd45,    "$PSTEP,00123,00045"};
        vt[1] = '{16'd0,     16'd0,     "$PSTEP,00000,00000"};
        vt[2] = '{16'd65535, 16'd65535, "$PSTEP,65535,65535"};
`endif

        #12;
        check(tx === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_state",
              $sformatf("tx/busy/done=%b%b%b", tx, busy, done), "100");
        @(negedge clk);
        rst = 1'b1;
        check_idle(5, "idle_after_reset");

        for (int i = 0; i < 3; i++) begin
            run_frame(vt[i].st, vt[i].sp, vt[i].head, $sformatf("vec%0d", i), 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
            check_idle(3, $sformatf("vec%0d idle", i));
        end

        for (int i = 0; i < 4; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom_range(0, 400));
            run_frame(a, b, model_head(int'(a), int'(b)), $sformatf("rand%0d", i), 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        end

        run_frame(16'd777, 16'd88, model_head(777, 88), "noisy", 1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
        check_idle(200, "noisy no_second_frame");

        // Abort in the middle of byte 8 ('0' of the step field): tx is low on data bit 2.
        @(negedge clk);
        step_count = 16'd123;
        spm = 16'd45;
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        repeat (850) @(posedge clk);
        #3;
        check(tx === 1'b0, "pre_rst_tx", $sformatf("%b", tx), "0");
        rst = 1'b0;
        #1;
        check(tx === 1'b1 && busy === 1'b0 && done === 1'b0, "async_rst",
              $sformatf("tx/busy/done=%b%b%b", tx, busy, done), "100");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_idle(4, "idle_after_abort");
        run_frame(16'd4321, 16'd99, model_head(4321, 99), "after_rst", 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

        run_frame(16'd10, 16'd20, model_head(10, 20), "chain_a", 1'b0, 1'b1, 16'd30000, 16'd7, 1'b0);
        run_frame(16'd30000, 16'd7, model_head(30000, 7), "chain_b", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        check_idle(5, "final idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
